vending_machine: RTL and testbench
==================================

VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 Parameter MAX_MONEY, default 40, sets the credit limit in money units.
REQ-002 Parameter INIT_STOCK, default 2, sets the initial stock count of each of the 4 items.
REQ-003 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: begins a transaction.
REQ-006 Port done_money, input, 1 bit: customer has finished inserting coins.
REQ-007 Port cancel, input, 1 bit: abort the transaction and refund all credit.
REQ-008 Port continue_buy, input, 1 bit: buy again using the remaining credit.
REQ-009 Port money, input, 3 bits: one-hot coin; 001=5, 010=10, 100=20, 000=no coin.
REQ-010 Port item_in, input, 2 bits: selected item, 0..3.
REQ-011 Port done, output, 1 bit: purchase succeeded.
REQ-012 Port item_out, output, 4 bits: one-hot dispensed item.
REQ-013 Port change, output, 8 bits: amount returned to the customer.
REQ-014 Port end_trans, output, 1 bit: transaction closed.

Function
REQ-015 Item prices SHALL be fixed: item0=15, item1=20, item2=25, item3=30.
REQ-016 The FSM SHALL use states IDLE, INSERT, CHECK, DISPENSE, REFUND and END, encoded in 4 bits.
REQ-017 In IDLE or END, start=1 SHALL move the FSM to INSERT next cycle, clear credit, and clear change, end_trans and done.
REQ-018 In INSERT, each clock with a valid nonzero money SHALL add the coin value to an 8-bit credit.
- Coins are accepted every cycle.
- Invalid codes (not one-hot) are ignored.
REQ-019 When credit ≥ MAX_MONEY, further coins SHALL be ignored; the credit is never truncated (max 55).
REQ-020 cancel SHALL have priority over done_money and money in every non-IDLE/END state.
- cancel moves the FSM to REFUND.
- The coin sampled in the same cycle is not added.
REQ-021 In INSERT, done_money=1 without cancel SHALL move the FSM to CHECK.
- item_in is latched at this moment.
- done_money is ignored in all other states.
REQ-022 CHECK SHALL take one cycle and branch on stock and credit:
- stock[item]==0 → REFUND, with out_stock asserted (internal).
- credit < price → back to INSERT, credit retained.
- otherwise → DISPENSE.
REQ-023 DISPENSE SHALL take one cycle and do the following:
- Pulse item_out one-hot for that cycle.
- Decrement stock[item].
- Set done=1.
- Set change = credit − price.
REQ-024 After DISPENSE the FSM SHALL branch on continue_buy:
- continue_buy=1 → INSERT with credit = change, and change cleared.
- otherwise → END.
REQ-025 REFUND SHALL set change = credit, clear credit and go to END; end_trans SHALL assert at most 2 cycles after cancel is sampled.
REQ-026 In END, end_trans=1 and SHALL stay high, with change and done held, until start or reset.
REQ-027 Outputs SHALL be registered; item_out SHALL be nonzero only during the DISPENSE cycle.

Reset
REQ-028 reset=1 at a clock edge SHALL force the following, regardless of state or a transaction in progress:
- state=IDLE, credit=0, done=0, item_out=0, change=0, end_trans=0, out_stock=0.
- Every stock counter = INIT_STOCK.
REQ-029 All inputs other than reset SHALL be ignored during reset.

Structure
REQ-030 A shared package vm_pkg SHALL hold:
- The state enum.
- Coin encodings and values.
- The item price table.
- MAX_MONEY/INIT_STOCK defaults.
REQ-031 One sub-module, vm_stock, SHALL hold the four stock counters and provide out_stock for the selected item and a decrement strobe input; the FSM and credit logic SHALL remain in vending_machine.

Verification
REQ-032 Refund: start, item 2, coins 5,10, cancel → end_trans within 3 cycles, change=15, done=0, item_out=0.
REQ-033 Purchase: start, item 1, coins 20,10, done_money → item_out=0010 for 1 cycle, done=1, change=10, end_trans=1.
REQ-034 Insufficient: start, item 3, coin 10, done_money → FSM returns to INSERT; then cancel → change=10.
REQ-035 Cap: start, coins 20,20,20 → credit=40, third coin ignored; cancel → change=40.
REQ-036 Stock-out: buy item 0 three times with 20 each → third attempt refunds change=20 with out_stock=1.
REQ-037 Continue: item 0, coins 20,20, done_money, continue_buy=1, then done_money → two dispenses, final change=10.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types, coin encodings, price table and default limits for the vending machine.
package vm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INSERT   = 4'd1,
        S_CHECK    = 4'd2,
        S_DISPENSE = 4'd3,
        S_REFUND   = 4'd4,
        S_END      = 4'd5
    } state_t;

    localparam logic [2:0] COIN_5  = 3'b001;
    localparam logic [2:0] COIN_10 = 3'b010;
    localparam logic [2:0] COIN_20 = 3'b100;

    localparam logic [7:0] VAL_5  = 8'd5;
    localparam logic [7:0] VAL_10 = 8'd10;
    localparam logic [7:0] VAL_20 = 8'd20;

    localparam int MAX_MONEY_DEF  = 40;
    localparam int INIT_STOCK_DEF = 2;

    // Codes that are not exactly one-hot carry no value.
    function automatic logic [7:0] coin_value(input logic [2:0] coin);
        case (coin)
            COIN_5:  return VAL_5;
            COIN_10: return VAL_10;
            COIN_20: return VAL_20;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] item_price(input logic [1:0] item);
        case (item)
            2'd0:    return 8'd15;
            2'd1:    return 8'd20;
            2'd2:    return 8'd25;
            default: return 8'd30;
        endcase
    endfunction

endpackage

// File: rtl/vm_stock.sv
// Per-item stock counters; reports whether the selected item is sold out.
module vm_stock
    import vm_pkg::*;
#(
    parameter int INIT_STOCK = INIT_STOCK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_sel,
    input  logic       i_dec,
    output logic       o_out_stock
);

    logic [7:0] r_stock [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_stock[i] <= 8'(INIT_STOCK);
            end
        end else if (i_dec && (r_stock[i_sel] != 8'd0)) begin
            r_stock[i_sel] <= r_stock[i_sel] - 8'd1;
        end
    end

    assign o_out_stock = (r_stock[i_sel] == 8'd0);

endmodule

// File: rtl/vending_machine.sv
// Vending machine controller: coin credit, item check, dispense and refund sequencing.
// States: IDLE wait start | INSERT take coins | CHECK stock/credit | DISPENSE pulse item | REFUND return credit | END hold result
module vending_machine
    import vm_pkg::*;
#(
    parameter int MAX_MONEY  = MAX_MONEY_DEF,
    parameter int INIT_STOCK = INIT_STOCK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       done_money,
    input  logic       cancel,
    input  logic       continue_buy,
    input  logic [2:0] money,
    input  logic [1:0] item_in,
    output logic       done,
    output logic [3:0] item_out,
    output logic [7:0] change,
    output logic       end_trans
);

    localparam logic [7:0] LP_MAX = 8'(MAX_MONEY);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_credit, w_credit_nxt;
    logic [7:0] r_change, w_change_nxt;
    logic       r_done, w_done_nxt;
    logic [3:0] r_item_out, w_item_out_nxt;
    logic       r_end_trans, w_end_trans_nxt;
    logic [1:0] r_item_sel, w_item_sel_nxt;
    logic       r_out_stock, w_out_stock_nxt;
    logic       w_dec;
    logic       w_sold_out;
    logic [7:0] w_coin;
    logic [7:0] w_price;

    vm_stock #(.INIT_STOCK(INIT_STOCK)) u_stock (
        .clk         (clk),
        .reset       (reset),
        .i_sel       (r_item_sel),
        .i_dec       (w_dec),
        .o_out_stock (w_sold_out)
    );

    assign w_coin  = coin_value(money);
    assign w_price = item_price(r_item_sel);

    always_comb begin
        w_state_nxt     = r_state;
        w_credit_nxt    = r_credit;
        w_change_nxt    = r_change;
        w_done_nxt      = r_done;
        w_item_out_nxt  = 4'b0000;
        w_end_trans_nxt = r_end_trans;
        w_item_sel_nxt  = r_item_sel;
        w_out_stock_nxt = r_out_stock;
        w_dec           = 1'b0;
        case (r_state)
            S_IDLE, S_END: begin
                if (start) begin
                    w_state_nxt     = S_INSERT;
                    w_credit_nxt    = 8'd0;
                    w_change_nxt    = 8'd0;
                    w_done_nxt      = 1'b0;
                    w_end_trans_nxt = 1'b0;
                    w_out_stock_nxt = 1'b0;
                end
            end
            S_INSERT: begin
                if (cancel) begin
                    w_state_nxt = S_REFUND;
                end else begin
                    // Credit may overshoot the limit by one coin; it is never clipped.
                    if (r_credit < LP_MAX) begin
                        w_credit_nxt = r_credit + w_coin;
                    end
                    if (done_money) begin
                        w_state_nxt    = S_CHECK;
                        w_item_sel_nxt = item_in;
                    end
                end
            end
            S_CHECK: begin
                if (cancel) begin
                    w_state_nxt = S_REFUND;
                end else if (w_sold_out) begin
                    w_state_nxt     = S_REFUND;
                    w_out_stock_nxt = 1'b1;
                end else if (r_credit < w_price) begin
                    w_state_nxt = S_INSERT;
                end else begin
                    w_state_nxt    = S_DISPENSE;
                    w_item_out_nxt = 4'b0001 << r_item_sel;
                    w_done_nxt     = 1'b1;
                    w_change_nxt   = r_credit - w_price;
                    w_credit_nxt   = r_credit - w_price;
                end
            end
            S_DISPENSE: begin
                w_dec = 1'b1;
                if (cancel) begin
                    w_state_nxt = S_REFUND;
                end else if (continue_buy) begin
                    w_state_nxt  = S_INSERT;
                    w_credit_nxt = r_change;
                    w_change_nxt = 8'd0;
                    w_done_nxt   = 1'b0;
                end else begin
                    w_state_nxt     = S_END;
                    w_end_trans_nxt = 1'b1;
                end
            end
            S_REFUND: begin
                w_state_nxt     = S_END;
                w_change_nxt    = r_credit;
                w_credit_nxt    = 8'd0;
                w_end_trans_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_credit    <= 8'd0;
            r_change    <= 8'd0;
            r_done      <= 1'b0;
            r_item_out  <= 4'b0000;
            r_end_trans <= 1'b0;
            r_item_sel  <= 2'd0;
            r_out_stock <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_change    <= w_change_nxt;
            r_done      <= w_done_nxt;
            r_item_out  <= w_item_out_nxt;
            r_end_trans <= w_end_trans_nxt;
            r_item_sel  <= w_item_sel_nxt;
            r_out_stock <= w_out_stock_nxt;
        end
    end

    assign done      = r_done;
    assign item_out  = r_item_out;
    assign change    = r_change;
    assign end_trans = r_end_trans;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench: transaction-level model predicts dispenses and closings; monitor compares.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       done_money = 1'b0;
    logic       cancel = 1'b0;
    logic       continue_buy = 1'b0;
    logic [2:0] money = 3'b000;
    logic [1:0] item_in = 2'd0;
    logic       done;
    logic [3:0] item_out;
    logic [7:0] change;
    logic       end_trans;

    vending_machine #(.MAX_MONEY(40), .INIT_STOCK(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .done_money   (done_money),
        .cancel       (cancel),
        .continue_buy (continue_buy),
        .money        (money),
        .item_in      (item_in),
        .done         (done),
        .item_out     (item_out),
        .change       (change),
        .end_trans    (end_trans)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] item; logic [7:0] chg; } disp_t;
    typedef struct { logic [7:0] chg; logic dn; logic oos; } end_t;

    disp_t q_disp[$];
    end_t  q_end[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_disp   = 0;

    // Transaction-level model
    int m_stock[4];
    int m_credit;
    bit m_open;
    int m_last_change;
    bit m_last_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int coin_val(input logic [2:0] c);
        if (c == 3'b001) return 5;
        if (c == 3'b010) return 10;
        if (c == 3'b100) return 20;
        return 0;
    endfunction

    task automatic cyc(input logic st, input logic dm, input logic cn, input logic cb,
                       input logic [2:0] mn, input logic [1:0] it);
        @(posedge clk);
        #1;
        start = st; done_money = dm; cancel = cn; continue_buy = cb; money = mn; item_in = it;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_end(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (end_trans === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic close_txn(input int chg, input bit dn);
        m_open = 1'b0;
        m_last_change = chg;
        m_last_done = dn;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'($urandom_range(0, 1)); cancel = 1'($urandom_range(0, 1));
        done_money = 1'($urandom_range(0, 1)); money = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1)); continue_buy = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; cancel = 1'b0; done_money = 1'b0; continue_buy = 1'b0; money = 3'b000;
        @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_item_out", 32'(item_out), 32'd0);
        check("reset_change", 32'(change), 32'd0);
        check("reset_end_trans", 32'(end_trans), 32'd0);
        check("reset_out_stock", 32'(dut.r_out_stock), 32'd0);
        for (int i = 0; i < 4; i++) m_stock[i] = 2;
        m_credit = 0;
        m_open = 1'b0;
    endtask

    task automatic do_start();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        m_credit = 0;
        m_open = 1'b1;
    endtask

    task automatic do_coin(input logic [2:0] c);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, c, 2'($urandom_range(0, 3)));
        if (m_credit < 40) m_credit += coin_val(c);
    endtask

    task automatic do_cancel();
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        q_end.push_back(end_t'{8'(m_credit), 1'b0, 1'b0});
        close_txn(m_credit, 1'b0);
        m_credit = 0;
        idle_cyc();
        wait_end("cancel_latency", 2);
    endtask

    task automatic do_buy(input int item, input bit cont);
        int price;
        price = 15 + 5 * item;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'(item));
        idle_cyc();
        if (m_stock[item] == 0) begin
            q_end.push_back(end_t'{8'(m_credit), 1'b0, 1'b1});
            close_txn(m_credit, 1'b0);
            m_credit = 0;
            wait_end("stockout_latency", 3);
        end else if (m_credit >= price) begin
            m_stock[item]--;
            m_credit -= price;
            q_disp.push_back(disp_t'{4'(1 << item), 8'(m_credit)});
            if (!cont) q_end.push_back(end_t'{8'(m_credit), 1'b1, 1'b0});
            cyc(1'b0, 1'b0, 1'b0, cont, 3'b000, 2'($urandom_range(0, 3)));
            idle_cyc();
            if (!cont) begin
                close_txn(m_credit, 1'b1);
                wait_end("dispense_end_latency", 2);
            end
        end
    endtask

    task automatic end_noise();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        idle_cyc();
        @(negedge clk);
        check("end_hold_trans", 32'(end_trans), 32'd1);
        check("end_hold_change", 32'(change), 32'(m_last_change));
        check("end_hold_done", 32'(done), 32'(m_last_done));
    endtask

    // Monitor: compares whatever the DUT presents against the queued predictions.
    initial begin : monitor
        logic prev_end;
        disp_t d;
        end_t  e;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_end = 1'b0;
            end else begin
                if (item_out !== 4'b0000 && item_out !== 4'bxxxx) begin
                    n_disp++;
                    if (q_disp.size() == 0) begin
                        check("unexpected_dispense", 32'(item_out), 32'd0);
                    end else begin
                        d = q_disp.pop_front();
                        check("disp_item", 32'(item_out), 32'(d.item));
                        check("disp_change", 32'(change), 32'(d.chg));
                        check("disp_done", 32'(done), 32'd1);
                    end
                end
                if (end_trans === 1'b1 && !prev_end) begin
                    if (q_end.size() == 0) begin
                        check("unexpected_end", 32'(end_trans), 32'd0);
                    end else begin
                        e = q_end.pop_front();
                        check("end_change", 32'(change), 32'(e.chg));
                        check("end_done", 32'(done), 32'(e.dn));
                        check("end_out_stock", 32'(dut.r_out_stock), 32'(e.oos));
                        check("end_item_out", 32'(item_out), 32'd0);
                    end
                end
                prev_end = (end_trans === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int d0;
        int steps;
        int r;

        // Refund after partial payment
        do_reset();
        do_start();
        do_coin(3'b001);
        do_coin(3'b010);
        do_cancel();
        check("r032_change", 32'(change), 32'd15);
        check("r032_done", 32'(done), 32'd0);
        check("r032_item_out", 32'(item_out), 32'd0);

        // Straight purchase of item 1
        do_start();
        do_coin(3'b100);
        do_coin(3'b010);
        d0 = n_disp;
        do_buy(1, 1'b0);
        check("r033_change", 32'(change), 32'd10);
        check("r033_done", 32'(done), 32'd1);
        check("r033_dispenses", 32'(n_disp - d0), 32'd1);

        // Insufficient credit returns to coin entry with credit kept
        do_start();
        do_coin(3'b010);
        do_buy(3, 1'b0);
        idle_cyc();
        @(negedge clk);
        check("r034_not_closed", 32'(end_trans), 32'd0);
        do_cancel();
        check("r034_change", 32'(change), 32'd10);

        // Credit cap: third coin ignored
        do_start();
        do_coin(3'b100);
        do_coin(3'b100);
        do_coin(3'b100);
        do_cancel();
        check("r035_change", 32'(change), 32'd40);

        // Stock-out on third purchase of item 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            do_start();
            do_coin(3'b100);
            do_buy(0, 1'b0);
        end
        check("r036_change", 32'(change), 32'd20);
        check("r036_done", 32'(done), 32'd0);
        check("r036_out_stock", 32'(dut.r_out_stock), 32'd1);

        // Continue buying on remaining credit
        do_reset();
        do_start();
        do_coin(3'b100);
        do_coin(3'b100);
        d0 = n_disp;
        do_buy(0, 1'b1);
        do_buy(0, 1'b0);
        check("r037_change", 32'(change), 32'd10);
        check("r037_dispenses", 32'(n_disp - d0), 32'd2);
        end_noise();

        // Randomized transactions
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            do_start();
            steps = 0;
            while (m_open && steps < 12) begin
                r = $urandom_range(0, 9);
                if (r < 6) do_coin(3'($urandom_range(0, 7)));
                else if (r < 9) do_buy($urandom_range(0, 3), ($urandom_range(0, 2) == 0));
                else do_cancel();
                steps++;
            end
            if (m_open) do_cancel();
            end_noise();
        end

        repeat (3) idle_cyc();
        check("disp_queue_empty", 32'(q_disp.size()), 32'd0);
        check("end_queue_empty", 32'(q_end.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
